// File: rtl/mem_seq_tester.sv
// Self-sequencing RAM exerciser: writes N_ENTRIES generated words into an internal
// synchronous RAM, reads them back, streams them out and counts mismatches.
module mem_seq_tester #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int N_ENTRIES = 4,
   parameter int CNT_W     = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] addr_stride,
   input  logic [DATA_W-1:0] seed,
   input  logic [DATA_W-1:0] data_step,
   input  logic              poke_we,
   input  logic [ADDR_W-1:0] poke_addr,
   input  logic [DATA_W-1:0] poke_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_next_s;
   logic                start_s;
   logic                advance_s;
   logic                rd_issue_s;
   logic                last_s;
   logic                mismatch_s;
   logic                ram_we_s;
   logic [ADDR_W-1:0]   ram_waddr_s;
   logic [DATA_W-1:0]   ram_wdata_s;

   logic [DATA_W-1:0]   ram_r [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0]   base_r;
   logic [ADDR_W-1:0]   stride_r;
   logic [DATA_W-1:0]   seed_r;
   logic [DATA_W-1:0]   step_r;
   logic [ADDR_W-1:0]   addr_acc_r;
   logic [DATA_W-1:0]   exp_acc_r;
   logic [IDX_W-1:0]    idx_r;
   logic [DATA_W-1:0]   rd_exp_r;
   logic [ADDR_W-1:0]   rd_addr_r;
   logic                busy_r;
   logic                done_r;
   logic [DATA_W-1:0]   data_out_r;
   logic                data_valid_r;
   logic [CNT_W-1:0]    err_count_r;
   logic [ADDR_W-1:0]   first_err_addr_r;

   assign last_s     = (idx_r == LAST_IDX);
   // data_valid_r doubles as "a read return is present this cycle"
   assign mismatch_s = data_valid_r && (data_out_r != rd_exp_r);

   // Next-state and per-cycle control strobes
   always_comb begin
      state_next_s = state_r;
      start_s      = 1'b0;
      advance_s    = 1'b0;
      rd_issue_s   = 1'b0;
      ram_we_s     = 1'b0;
      ram_waddr_s  = addr_acc_r;
      ram_wdata_s  = exp_acc_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               start_s = 1'b1;
               if (mode) begin
                  state_next_s = ST_READ;
               end else begin
                  state_next_s = ST_WRITE;
               end
            end else if (poke_we) begin
               ram_we_s    = 1'b1;
               ram_waddr_s = poke_addr;
               ram_wdata_s = poke_data;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            ram_we_s  = 1'b1;
            advance_s = 1'b1;
            if (last_s) begin
               state_next_s = ST_READ;
            end else begin
               state_next_s = ST_WRITE;
            end
         end
         ST_READ: begin
            rd_issue_s = 1'b1;
            advance_s  = 1'b1;
            if (last_s) begin
               state_next_s = ST_DRAIN;
            end else begin
               state_next_s = ST_READ;
            end
         end
         ST_DRAIN: state_next_s = ST_DONE;
         ST_DONE:  state_next_s = ST_IDLE;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // State register with registered busy/done derived from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s != ST_IDLE);
         done_r  <= (state_next_s == ST_DONE);
      end
   end

   // RAM write port; contents survive reset but no write lands on a reset edge
   always_ff @(posedge clock) begin
      if (ram_we_s && !reset) begin
         ram_r[ram_waddr_s] <= ram_wdata_s;
      end
   end

   // Run parameters, entry accumulators, synchronous read and mismatch accounting
   always_ff @(posedge clock) begin
      if (reset) begin
         base_r           <= {ADDR_W{1'b0}};
         stride_r         <= {ADDR_W{1'b0}};
         seed_r           <= {DATA_W{1'b0}};
         step_r           <= {DATA_W{1'b0}};
         addr_acc_r       <= {ADDR_W{1'b0}};
         exp_acc_r        <= {DATA_W{1'b0}};
         idx_r            <= {IDX_W{1'b0}};
         rd_exp_r         <= {DATA_W{1'b0}};
         rd_addr_r        <= {ADDR_W{1'b0}};
         data_out_r       <= {DATA_W{1'b0}};
         data_valid_r     <= 1'b0;
         err_count_r      <= {CNT_W{1'b0}};
         first_err_addr_r <= {ADDR_W{1'b0}};
      end else begin
         data_valid_r <= rd_issue_s;
         if (rd_issue_s) begin
            data_out_r <= ram_r[addr_acc_r];
            rd_exp_r   <= exp_acc_r;
            rd_addr_r  <= addr_acc_r;
         end
         if (start_s) begin
            base_r           <= base_addr;
            stride_r         <= addr_stride;
            seed_r           <= seed;
            step_r           <= data_step;
            addr_acc_r       <= base_addr;
            exp_acc_r        <= seed;
            idx_r            <= {IDX_W{1'b0}};
            err_count_r      <= {CNT_W{1'b0}};
            first_err_addr_r <= {ADDR_W{1'b0}};
         end else begin
            // Rewind after the last entry so the read phase replays the same sequence
            if (advance_s) begin
               if (last_s) begin
                  addr_acc_r <= base_r;
                  exp_acc_r  <= seed_r;
                  idx_r      <= {IDX_W{1'b0}};
               end else begin
                  addr_acc_r <= addr_acc_r + stride_r;
                  exp_acc_r  <= exp_acc_r + step_r;
                  idx_r      <= idx_r + IDX_W'(1);
               end
            end
            if (mismatch_s) begin
               if (err_count_r == {CNT_W{1'b0}}) begin
                  first_err_addr_r <= rd_addr_r;
               end
               if (err_count_r != CNT_MAX) begin
                  err_count_r <= err_count_r + CNT_W'(1);
               end
            end
         end
      end
   end

   assign busy           = busy_r;
   assign done           = done_r;
   assign data_out       = data_out_r;
   assign data_valid     = data_valid_r;
   assign err_count      = err_count_r;
   assign first_err_addr = first_err_addr_r;

endmodule

// File: tb/tb_mem_seq_tester.sv
// Directed, table-driven bench for mem_seq_tester; a second instance with a
// 2-bit error counter shares the stimulus to exercise saturation.
module tb_mem_seq_tester;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       mode;
   logic [7:0] base_addr;
   logic [7:0] addr_stride;
   logic [7:0] seed;
   logic [7:0] data_step;
   logic       poke_we;
   logic [7:0] poke_addr;
   logic [7:0] poke_data;

   logic       busy, done, data_valid;
   logic [7:0] data_out, err_count, first_err_addr;
   logic       busy2, done2, data_valid2;
   logic [7:0] data_out2, first_err_addr2;
   logic [1:0] err_count2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   mem_seq_tester dut (
      .clock(clock), .reset(reset), .start(start), .mode(mode),
      .base_addr(base_addr), .addr_stride(addr_stride), .seed(seed), .data_step(data_step),
      .poke_we(poke_we), .poke_addr(poke_addr), .poke_data(poke_data),
      .busy(busy), .done(done), .data_out(data_out), .data_valid(data_valid),
      .err_count(err_count), .first_err_addr(first_err_addr)
   );

   mem_seq_tester #(.CNT_W(2)) dut_sat (
      .clock(clock), .reset(reset), .start(start), .mode(mode),
      .base_addr(base_addr), .addr_stride(addr_stride), .seed(seed), .data_step(data_step),
      .poke_we(poke_we), .poke_addr(poke_addr), .poke_data(poke_data),
      .busy(busy2), .done(done2), .data_out(data_out2), .data_valid(data_valid2),
      .err_count(err_count2), .first_err_addr(first_err_addr2)
   );

   typedef struct packed {
      logic [3:0]      id;
      logic            mode;
      logic [7:0]      stride;
      logic [1:0]      poke_kind;   // 0 none, 1 poke before start, 2 poke with start
      logic [7:0]      poke_addr;
      logic [7:0]      poke_data;
      logic [3:0][7:0] exp_data;
      logic [7:0]      exp_err;
      logic [7:0]      exp_first;
      logic [7:0]      exp_valid1;
      logic [7:0]      exp_done;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] id, input logic m, input logic [7:0] st,
                               input logic [1:0] pk, input logic [7:0] pa, input logic [7:0] pd,
                               input logic [31:0] dat, input logic [7:0] err, input logic [7:0] first);
      vec_t v;
      v.id         = id;
      v.mode       = m;
      v.stride     = st;
      v.poke_kind  = pk;
      v.poke_addr  = pa;
      v.poke_data  = pd;
      v.exp_data   = dat;
      v.exp_err    = err;
      v.exp_first  = first;
      v.exp_valid1 = m ? 8'd2 : 8'd6;
      v.exp_done   = m ? 8'd6 : 8'd10;
      return v;
   endfunction

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clock);
      poke_we   = 1'b1;
      poke_addr = a;
      poke_data = d;
      @(negedge clock);
      poke_we   = 1'b0;
   endtask

   task automatic set_params(input logic m, input logic [7:0] st);
      mode        = m;
      base_addr   = 8'h0F;
      addr_stride = st;
      seed        = 8'h1E;
      data_step   = 8'hE5;
   endtask

   // One run: start edge ends cycle 0; samples taken at negedges of cycles 1, 2, ...
   task automatic run_vec(input vec_t v);
      int done_c;
      int nvalid;
      if (v.poke_kind == 2'd1) poke(v.poke_addr, v.poke_data);
      @(negedge clock);
      set_params(v.mode, v.stride);
      start = 1'b1;
      if (v.poke_kind == 2'd2) begin
         poke_we   = 1'b1;
         poke_addr = v.poke_addr;
         poke_data = v.poke_data;
      end
      @(negedge clock);
      start       = 1'b0;
      mode        = ~v.mode;
      base_addr   = 8'hAA;
      addr_stride = ~v.stride;
      seed        = 8'h55;
      data_step   = 8'h01;
      poke_we     = 1'b1;
      poke_addr   = 8'h0F;
      poke_data   = ~v.exp_data[0];
      check($sformatf("v%0d_busy_run", v.id), {31'd0, busy}, 32'd1);
      done_c = 0;
      nvalid = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge clock);
         if (data_valid) begin
            check($sformatf("v%0d_valid_cycle%0d", v.id, nvalid), c, v.exp_valid1 + nvalid);
            if (nvalid < 4) check($sformatf("v%0d_data%0d", v.id, nvalid), {24'd0, data_out},
                                  {24'd0, v.exp_data[nvalid[1:0]]});
            nvalid++;
         end
         if (done) begin
            done_c = c;
            break;
         end
      end
      poke_we = 1'b0;
      check($sformatf("v%0d_done_cycle", v.id), done_c, {24'd0, v.exp_done});
      check($sformatf("v%0d_valid_count", v.id), nvalid, 32'd4);
      check($sformatf("v%0d_err_count", v.id), {24'd0, err_count}, {24'd0, v.exp_err});
      check($sformatf("v%0d_first_err", v.id), {24'd0, first_err_addr}, {24'd0, v.exp_first});
      @(negedge clock);
      check($sformatf("v%0d_idle_busy", v.id), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_done_pulse", v.id), {31'd0, done}, 32'd0);
   endtask

   initial begin
      int seen;
      int nd;
      int dc [2];

      reset = 1'b1;
      start = 1'b0;
      poke_we = 1'b0;
      poke_addr = 8'h00;
      poke_data = 8'h00;
      set_params(1'b0, 8'hE1);

      vecs[0] = mk(4'd0, 1'b0, 8'hE1, 2'd0, 8'h00, 8'h00, 32'hCDE8031E, 8'd0, 8'h00);
      vecs[1] = mk(4'd1, 1'b1, 8'hE1, 2'd1, 8'hF0, 8'hFF, 32'hCDE8FF1E, 8'd1, 8'hF0);
      vecs[2] = mk(4'd2, 1'b0, 8'h00, 2'd0, 8'h00, 8'h00, 32'hCDCDCDCD, 8'd3, 8'h0F);
      vecs[3] = mk(4'd3, 1'b0, 8'hE1, 2'd0, 8'h00, 8'h00, 32'hCDE8031E, 8'd0, 8'h00);
      vecs[4] = mk(4'd4, 1'b1, 8'hE1, 2'd2, 8'h0F, 8'h55, 32'hCDE8031E, 8'd0, 8'h00);
      vecs[5] = mk(4'd5, 1'b1, 8'hE1, 2'd0, 8'h00, 8'h00, 32'hCDE8031E, 8'd0, 8'h00);

      repeat (3) @(negedge clock);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_valid", {31'd0, data_valid}, 32'd0);
      check("rst_data", {24'd0, data_out}, 32'd0);
      check("rst_err", {24'd0, err_count}, 32'd0);
      check("rst_first", {24'd0, first_err_addr}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Reset in cycle 3 of a mode 0 run over deliberately corrupted entries 0 and 1
      poke(8'h0F, 8'h00);
      poke(8'hF0, 8'h00);
      @(negedge clock);
      set_params(1'b0, 8'hE1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_err", {24'd0, err_count}, 32'd0);
      check("abort_data", {24'd0, data_out}, 32'd0);
      reset = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clock);
         if (done) seen++;
      end
      check("abort_no_done", seen, 32'd0);
      run_vec(mk(4'd6, 1'b1, 8'hE1, 2'd0, 8'h00, 8'h00, 32'hCDE8031E, 8'd0, 8'h00));

      // start held high: second run begins on the IDLE cycle after DONE
      @(negedge clock);
      set_params(1'b1, 8'hE1);
      start = 1'b1;
      nd = 0;
      dc[0] = 0;
      dc[1] = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clock);
         if (done) begin
            if (nd < 2) dc[nd] = c;
            nd++;
            if (nd == 2) break;
         end
      end
      start = 1'b0;
      check("held_done1", dc[0], 32'd6);
      check("held_done2", dc[1], 32'd13);
      check("held_err", {24'd0, err_count}, 32'd0);
      repeat (3) @(negedge clock);
      check("held_idle", {31'd0, busy}, 32'd0);

      // Four forced mismatches: 8-bit counter reads 4, 2-bit counter saturates at 3
      poke(8'h0F, 8'h00);
      poke(8'hF0, 8'h00);
      poke(8'hD1, 8'h00);
      poke(8'hB2, 8'h00);
      run_vec(mk(4'd7, 1'b1, 8'hE1, 2'd0, 8'h00, 8'h00, 32'h00000000, 8'd4, 8'h0F));
      check("sat_err", {30'd0, err_count2}, 32'd3);
      check("sat_first", {24'd0, first_err_addr2}, 32'h0F);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
